spi_regfile: RTL and testbench
==============================

// Module: spi_regfile
// PURPOSE
//  Byte-level register bank placed directly downstream of the SPI byte slave.
//  Consumes its received-byte strobe/data; decodes a command byte; performs
//  auto-incrementing burst writes/reads on REG_NUM x 8-bit registers.
//  Supplies the next transmit byte back to the slave's parallel load input.
//  Exposes all registers to the core as a flat bus plus a write strobe.
// PARAMETERS
//  REG_NUM     16     number of 8-bit registers, 1..128
//  STATUS_BYTE 8'hA5  byte shifted out during the command byte and write bursts
// PORTS
//  clk_i        in   1          system clock
//  rst_i        in   1          synchronous reset, active-high
//  cs_n_i       in   1          SPI chip select, same as slave's, sync to clk_i
//  byte_done_i  in   1          1-cycle strobe: byte received (slave done_o)
//  byte_data_i  in   8          received byte, valid with byte_done_i
//  tx_data_o    out  8          next byte to transmit (to slave data_i)
//  wr_stb_o     out  1          1-cycle pulse: register written
//  wr_addr_o    out  7          address of the write, valid with wr_stb_o
//  reg_o        out  8*REG_NUM  all registers, reg k at [8k+7:8k]
// BEHAVIOUR
//  Reset: all regs 0; tx_data_o=STATUS_BYTE; wr_stb_o=0; wr_addr_o=0; FSM=IDLE.
//  Command byte {rw, a[6:0]}: rw=1 write burst, rw=0 read burst.
//  FSM states: IDLE, CMD, WRITE, READ.
//   IDLE: cs_n_i=0 -> CMD. byte_done_i ignored while cs_n_i=1.
//   CMD: byte_done_i -> rw ? WRITE : READ. ptr<=a.
//    Read: tx_data_o<=rd(a), ptr<=a+1.
//    Write: tx_data_o<=STATUS_BYTE.
//   WRITE: each byte_done_i -> reg[ptr]<=byte_data_i if ptr<REG_NUM.
//    wr_stb_o=1 and wr_addr_o=ptr next cycle; ptr<=ptr+1.
//   READ: each byte_done_i -> tx_data_o<=rd(ptr); ptr<=ptr+1.
//  Any state: cs_n_i=1 -> IDLE next cycle; tx_data_o<=STATUS_BYTE; burst ends.
//   A partial byte is never seen: no done strobe occurs.
//  Latency: tx_data_o and reg update registered, 1 clk after byte_done_i.
//   Must settle before the slave's next SCLK falling-edge load; guaranteed
//   for SCLK <= clk_i/4.
//  rd(p) = reg[p] if p<REG_NUM, else 8'h00. ptr is 7 bits, wraps 127->0.
//  Writes with ptr>=REG_NUM are dropped: no reg change, no wr_stb_o.
//  byte_done_i coincident with cs_n_i rising: cs_n_i wins; byte discarded.
//  rst_i mid-burst: immediate full reset regardless of cs_n_i.
//   FSM re-enters CMD only on the next cycle with cs_n_i=0.
// CONFIGURATION
//  SPI_REGFILE_WR_LOCK_EN defined: reg[REG_NUM-1] bit0 is a lock bit.
//   While set, writes to every other address are dropped (no wr_stb_o).
//   Writes to reg[REG_NUM-1] always allowed. Reads unaffected.
//  Undefined: no lock; reg[REG_NUM-1] is an ordinary register.
// TESTING
//  Reset, cs_n=1 -> tx_data_o=8'hA5, reg_o=0, wr_stb_o never pulses.
//  cs_n=0; bytes 8'h82,8'h11,8'h22; cs_n=1 -> reg2=8'h11, reg3=8'h22.
//   Two wr_stb_o pulses, addr 2 then 3.
//  With reg2=8'h11, reg3=8'h22: cs_n=0; byte 8'h02 -> tx_data_o=8'h11.
//   Next byte -> 8'h22. Next byte -> reg4 value.
//  REG_NUM=16: write burst at addr 8'h8F with 2 bytes -> reg15 written.
//   Addr 16 dropped, no wr_stb_o for it. Read at addr 8'h10 returns 8'h00.
//  Write 8'h81 then cs_n=1 before data byte -> no write; next cs_n=0 -> CMD.
//   tx_data_o=8'hA5.
//  WR_LOCK_EN: write 8'h01 to reg15, then write reg0=8'h55 -> reg0 stays 0.
//   Clear reg15 bit0 -> reg0 write succeeds.

Source files
------------

// File: rtl/spi_regfile.sv
// rtl/spi_regfile.sv - SPI byte-stream register bank with auto-incrementing burst read/write
// Optional write lock on the last register: define SPI_REGFILE_WR_LOCK_EN.
module spi_regfile #(
    parameter int         REG_NUM     = 16,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cs_n_i,
    input  logic                 byte_done_i,
    input  logic [7:0]           byte_data_i,
    output logic [7:0]           tx_data_o,
    output logic                 wr_stb_o,
    output logic [6:0]           wr_addr_o,
    output logic [8*REG_NUM-1:0] reg_o
);

    localparam logic [7:0] LP_NUM  = 8'(REG_NUM);
    localparam logic [6:0] LP_LAST = 7'(REG_NUM - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WRITE, ST_READ} state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_regs [REG_NUM];
    logic [6:0] r_ptr;
    logic [7:0] r_tx;
    logic       r_wr_stb;
    logic [6:0] r_wr_addr;

    logic       w_accept;
    logic       w_cmd_rd;
    logic       w_cmd_wr;
    logic       w_wr_byte;
    logic       w_rd_byte;
    logic       w_wr_ok;
    logic       w_lock;

    // Out-of-range addresses read as zero.
    function automatic logic [7:0] f_rd(input logic [6:0] p);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < REG_NUM; k++) begin
            if (p == 7'(k)) v = r_regs[k];
        end
        return v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (cs_n_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_CMD;
                ST_CMD:  if (byte_done_i) w_state_nxt = byte_data_i[7] ? ST_WRITE : ST_READ;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_accept  = byte_done_i && !cs_n_i;
        w_cmd_rd  = w_accept && (r_state == ST_CMD) && !byte_data_i[7];
        w_cmd_wr  = w_accept && (r_state == ST_CMD) &&  byte_data_i[7];
        w_wr_byte = w_accept && (r_state == ST_WRITE);
        w_rd_byte = w_accept && (r_state == ST_READ);
    end

`ifdef SPI_REGFILE_WR_LOCK_EN
    assign w_lock = r_regs[REG_NUM-1][0];
`else
    assign w_lock = 1'b0;
`endif

    // The lock register itself stays writable so the lock can be released.
    assign w_wr_ok = ({1'b0, r_ptr} < LP_NUM) && (!w_lock || (r_ptr == LP_LAST));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < REG_NUM; k++) r_regs[k] <= 8'h00;
            r_ptr     <= 7'd0;
            r_tx      <= STATUS_BYTE;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 7'd0;
        end else begin
            r_wr_stb <= 1'b0;
            if (cs_n_i) begin
                r_tx <= STATUS_BYTE;
            end else if (w_cmd_rd) begin
                r_tx  <= f_rd(byte_data_i[6:0]);
                r_ptr <= byte_data_i[6:0] + 7'd1;
            end else if (w_cmd_wr) begin
                r_tx  <= STATUS_BYTE;
                r_ptr <= byte_data_i[6:0];
            end else if (w_wr_byte) begin
                r_ptr <= r_ptr + 7'd1;
                if (w_wr_ok) begin
                    for (int k = 0; k < REG_NUM; k++) begin
                        if (r_ptr == 7'(k)) r_regs[k] <= byte_data_i;
                    end
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_ptr;
                end
            end else if (w_rd_byte) begin
                r_tx  <= f_rd(r_ptr);
                r_ptr <= r_ptr + 7'd1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < REG_NUM; k++) reg_o[8*k +: 8] = r_regs[k];
    end

    assign tx_data_o = r_tx;
    assign wr_stb_o  = r_wr_stb;
    assign wr_addr_o = r_wr_addr;

endmodule

// File: tb/tb_spi_regfile.sv
// tb/tb_spi_regfile.sv - scoreboard bench for spi_regfile with randomized bursts
module tb_spi_regfile;

    localparam int         N  = 16;
    localparam logic [7:0] ST = 8'hA5;

    logic           clk = 1'b0;
    logic           rst;
    logic           cs_n;
    logic           byte_done;
    logic [7:0]     byte_data;
    logic [7:0]     tx_data;
    logic           wr_stb;
    logic [6:0]     wr_addr;
    logic [8*N-1:0] reg_flat;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  exp_tx [$];
    logic [14:0] exp_wr [$];
    logic [7:0]  m_regs [N];
    logic [7:0]  bq [$];
    logic        seen = 1'b0;

    spi_regfile #(.REG_NUM(N), .STATUS_BYTE(ST)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cs_n_i      (cs_n),
        .byte_done_i (byte_done),
        .byte_data_i (byte_data),
        .tx_data_o   (tx_data),
        .wr_stb_o    (wr_stb),
        .wr_addr_o   (wr_addr),
        .reg_o       (reg_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_rd(input int p);
        return (p < N) ? m_regs[p] : 8'h00;
    endfunction

    function automatic bit m_can_write(input int p);
        if (p >= N) return 1'b0;
`ifdef SPI_REGFILE_WR_LOCK_EN
        if (m_regs[N-1][0] && p != N-1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [8*N-1:0] m_flat();
        logic [8*N-1:0] f;
        for (int k = 0; k < N; k++) f[8*k +: 8] = m_regs[k];
        return f;
    endfunction

    // Monitor: every accepted byte yields one tx_data_o value; every wr_stb_o one write.
    always @(posedge clk) seen <= byte_done && !cs_n && !rst;

    always @(negedge clk) begin
        logic [7:0]  e;
        logic [14:0] w;
        if (seen) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
            else begin
                e = exp_tx.pop_front();
                chk("tx_data", tx_data, e);
            end
        end
        if (wr_stb) begin
            if (exp_wr.size() == 0) chk("wr_stb_unexpected", {wr_addr}, 128'h1_0000);
            else begin
                w = exp_wr.pop_front();
                chk("wr_addr", wr_addr, w[14:8]);
                chk("wr_data", reg_flat[8*int'(w[14:8]) +: 8], w[7:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_done = 1'b1;
        byte_data = b;
        @(negedge clk);
        byte_done = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clk);
    endtask

    // Expected responses come straight from the burst rules: address a+i, rd()=0 beyond N.
    task automatic send_seq();
        logic [7:0] cmd;
        bit         rw;
        int         p;
        cmd = bq[0];
        rw  = cmd[7];
        p   = int'(cmd[6:0]);
        exp_tx.push_back(rw ? ST : m_rd(p));
        if (!rw) p = (p + 1) % 128;
        send_byte(cmd);
        for (int i = 1; i < bq.size(); i++) begin
            if (rw) begin
                exp_tx.push_back(ST);
                if (m_can_write(p)) begin
                    m_regs[p] = bq[i];
                    exp_wr.push_back({7'(p), bq[i]});
                end
            end else begin
                exp_tx.push_back(m_rd(p));
            end
            p = (p + 1) % 128;
            send_byte(bq[i]);
        end
    endtask

    task automatic end_burst();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("tx_idle", tx_data, ST);
        chk("queues_drained", exp_tx.size() + exp_wr.size(), 0);
        chk("regs", reg_flat, m_flat());
    endtask

    task automatic burst();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        send_seq();
        end_burst();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cs_n = 1'b1; byte_done = 1'b0; byte_data = 8'h00;
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx_data, ST);
        chk("reset_regs", reg_flat, 0);
        chk("reset_wr_stb", wr_stb, 0);
        chk("reset_wr_addr", wr_addr, 0);

        // Strobes while deselected are ignored.
        send_byte(8'h83);
        send_byte(8'h5A);
        chk("idle_tx", tx_data, ST);
        chk("idle_regs", reg_flat, 0);

        bq = '{8'h82, 8'h11, 8'h22};             burst();
        bq = '{8'h02, 8'h00, 8'h00, 8'h00};      burst();
        bq = '{8'h8F, 8'hAA, 8'hBB};             burst();
        bq = '{8'h10, 8'h00};                    burst();
        bq = '{8'hFF, 8'h01, 8'h02, 8'h03};      burst();
        bq = '{8'h7E, 8'h00, 8'h00, 8'h00};      burst();

        // Command only, then deselect: nothing written; next select starts fresh.
        bq = '{8'h81};                           burst();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("cmd_tx_status", tx_data, ST);
        bq = '{8'h01, 8'h00};
        send_seq();
        end_burst();

`ifdef SPI_REGFILE_WR_LOCK_EN
        bq = '{8'h8F, 8'h01};                    burst();
        bq = '{8'h80, 8'h55};                    burst();
        chk("locked_reg0", reg_flat[7:0], 8'h00);
        bq = '{8'h8F, 8'h00};                    burst();
        bq = '{8'h80, 8'h55};                    burst();
        chk("unlocked_reg0", reg_flat[7:0], 8'h55);
`else
        bq = '{8'h8F, 8'h01};                    burst();
        bq = '{8'h80, 8'h55};                    burst();
        chk("plain_reg0", reg_flat[7:0], 8'h55);
`endif

        // Final byte coincides with deselect: it must be discarded.
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        bq = '{8'h83, 8'h3C};
        send_seq();
        @(negedge clk);
        byte_done = 1'b1; byte_data = 8'hC3; cs_n = 1'b1;
        @(negedge clk);
        byte_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("coincident_reg4", reg_flat[39:32], m_regs[4]);
        chk("coincident_regs", reg_flat, m_flat());

        // Reset mid-burst with cs_n held low, then a new burst without reselecting.
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        bq = '{8'h85, 8'h91, 8'h92};
        send_seq();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        chk("midrst_regs", reg_flat, 0);
        chk("midrst_tx", tx_data, ST);
        repeat (2) @(negedge clk);
        bq = '{8'h85, 8'h77};
        send_seq();
        end_burst();

        for (int r = 0; r < 40; r++) begin
            logic [6:0] a;
            int         len;
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(118, 127)) : 7'($urandom_range(0, 18));
            len = $urandom_range(0, 5);
            bq  = {};
            bq.push_back({1'($urandom_range(0, 1)), a});
            for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
            burst();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
